// File: rtl/spi_fsm_param.sv
// spi_fsm_param
//   Control FSM for the SPI memory slave. Sequences the header (address +
//   R/W flag), the read load/shift-out and the write shift-in/commit, with
//   optional burst auto-increment and abort whenever cs is released mid-frame.
//
// Parameters
//   ADDR_BITS  : header length in bits (address MSBs + R/W in LSB), >= 2
//   DATA_WIDTH : bits per data word, >= 2
//   BURST_EN   : 1 = keep transferring words while cs is low, address auto-increments
//
// Ports
//   sclk            in  SPI clock, all state changes on posedge
//   rst_n           in  asynchronous active-low reset
//   cs              in  chip select, active low, synchronous to sclk
//   shift_reg_out_0 in  shift-register bit 0, R/W flag at end of header (1 = read)
//   miso_buff       out MISO buffer enable
//   dm_we           out data memory write enable
//   addr_we         out address latch write enable
//   sr_we           out shift register parallel-load enable
//   addr_inc        out address latch increment pulse (burst only)
//   busy            out high whenever the FSM is not in STANDBY
module spi_fsm_param #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_EN   = 0
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic cs,
  input  logic shift_reg_out_0,
  output logic miso_buff,
  output logic dm_we,
  output logic addr_we,
  output logic sr_we,
  output logic addr_inc,
  output logic busy
);

  localparam int MAXW = (ADDR_BITS > DATA_WIDTH) ? ADDR_BITS : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW);

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS - 1);
  // Shift states end one count early: the load/store cycle completes the word.
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 2);
  localparam bit            BURST     = (BURST_EN != 0);

  typedef enum logic [2:0] {
    ST_STANDBY     = 3'd0,
    ST_GET_ADDR    = 3'd1,
    ST_READ_LOAD   = 3'd2,
    ST_READ_SHIFT  = 3'd3,
    ST_WRITE_SHIFT = 3'd4,
    ST_WRITE_STORE = 3'd5
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            w_count_addr_last;
  logic            w_count_data_last;

  assign w_count_addr_last = (r_count == ADDR_LAST);
  assign w_count_data_last = (r_count == DATA_LAST);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STANDBY;
      r_count <= '0;
    end else if (cs && (r_state != ST_STANDBY)) begin
      // cs release aborts any frame; a partial write word is simply dropped
      r_state <= ST_STANDBY;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_STANDBY: begin
          r_count <= '0;
          if (!cs) r_state <= ST_GET_ADDR;
        end
        ST_GET_ADDR: begin
          if (w_count_addr_last) begin
            r_state <= shift_reg_out_0 ? ST_READ_LOAD : ST_WRITE_SHIFT;
            r_count <= '0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        ST_READ_LOAD: begin
          r_state <= ST_READ_SHIFT;
          r_count <= '0;
        end
        ST_READ_SHIFT: begin
          if (w_count_data_last) begin
            r_state <= BURST ? ST_READ_LOAD : ST_STANDBY;
            r_count <= '0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        ST_WRITE_SHIFT: begin
          if (w_count_data_last) begin
            r_state <= ST_WRITE_STORE;
            r_count <= '0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        ST_WRITE_STORE: begin
          r_state <= BURST ? ST_WRITE_SHIFT : ST_STANDBY;
          r_count <= '0;
        end
        default: begin
          r_state <= ST_STANDBY;
          r_count <= '0;
        end
      endcase
    end
  end

  // Outputs are decoded straight from state/count so they fall with rst_n.
  // dm_we/addr_inc in WRITE_STORE are gated by ~cs so an aborting edge never commits.
  always_comb begin
    busy      = (r_state != ST_STANDBY);
    addr_we   = (r_state == ST_GET_ADDR);
    sr_we     = (r_state == ST_READ_LOAD);
    miso_buff = (r_state == ST_READ_SHIFT);
    dm_we     = (r_state == ST_WRITE_STORE) && !cs;
    addr_inc  = BURST && (((r_state == ST_READ_SHIFT) && w_count_data_last) ||
                          ((r_state == ST_WRITE_STORE) && !cs));
  end

endmodule

// File: tb/tb_spi_fsm_param.sv
module tb_spi_fsm_param;

  localparam logic [5:0] BUSY = 6'b100000;
  localparam logic [5:0] AINC = 6'b010000;
  localparam logic [5:0] AWE  = 6'b001000;
  localparam logic [5:0] SWE  = 6'b000100;
  localparam logic [5:0] DMW  = 6'b000010;
  localparam logic [5:0] MISO = 6'b000001;

  // instance 0: defaults, 1: burst 16-bit data, 2: burst 16-bit header
  localparam int MA[3] = '{8, 8, 16};
  localparam int MD[3] = '{8, 16, 8};
  localparam int MB[3] = '{0, 1, 1};

  logic sclk = 1'b0;
  logic rst_n;
  logic cs  = 1'b1;
  logic sr0 = 1'b0;
  logic miso_b[3], dm[3], awe[3], swe[3], ainc[3], bsy[3];

  int checks = 0;
  int errors = 0;

  always #5 sclk = ~sclk;

  spi_fsm_param #(.ADDR_BITS(8), .DATA_WIDTH(8), .BURST_EN(0)) u_def (
    .sclk(sclk), .rst_n(rst_n), .cs(cs), .shift_reg_out_0(sr0),
    .miso_buff(miso_b[0]), .dm_we(dm[0]), .addr_we(awe[0]), .sr_we(swe[0]),
    .addr_inc(ainc[0]), .busy(bsy[0]));

  spi_fsm_param #(.ADDR_BITS(8), .DATA_WIDTH(16), .BURST_EN(1)) u_bw (
    .sclk(sclk), .rst_n(rst_n), .cs(cs), .shift_reg_out_0(sr0),
    .miso_buff(miso_b[1]), .dm_we(dm[1]), .addr_we(awe[1]), .sr_we(swe[1]),
    .addr_inc(ainc[1]), .busy(bsy[1]));

  spi_fsm_param #(.ADDR_BITS(16), .DATA_WIDTH(8), .BURST_EN(1)) u_ab (
    .sclk(sclk), .rst_n(rst_n), .cs(cs), .shift_reg_out_0(sr0),
    .miso_buff(miso_b[2]), .dm_we(dm[2]), .addr_we(awe[2]), .sr_we(swe[2]),
    .addr_inc(ainc[2]), .busy(bsy[2]));

  // Reference model: position within the frame (1 = first cycle after start edge)
  bit act[3];
  int pos[3];
  bit rw[3];

  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) act[k] <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!act[k]) begin
          if (!cs) begin
            act[k] <= 1'b1;
            pos[k] <= 1;
          end
        end else if (cs) begin
          act[k] <= 1'b0;
        end else begin
          if (pos[k] == MA[k]) rw[k] <= sr0;
          if (MB[k] == 0 && pos[k] == MA[k] + MD[k]) act[k] <= 1'b0;
          else pos[k] <= pos[k] + 1;
        end
      end
    end
  end

  function automatic logic [5:0] model_exp(input int k);
    logic [5:0] e;
    int d, o;
    e = '0;
    if (act[k]) begin
      e = BUSY;
      if (pos[k] <= MA[k]) begin
        e |= AWE;
      end else begin
        d = pos[k] - MA[k];
        o = (d - 1) % MD[k];
        if (rw[k]) begin
          if (o == 0) e |= SWE;
          else        e |= MISO;
          if (MB[k] != 0 && o == MD[k] - 1) e |= AINC;
        end else if (o == MD[k] - 1 && !cs) begin
          e |= DMW;
          if (MB[k] != 0) e |= AINC;
        end
      end
    end
    return e;
  endfunction

  function automatic logic [5:0] get_out(input int k);
    return {bsy[k], ainc[k], awe[k], swe[k], dm[k], miso_b[k]};
  endfunction

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (busy,ainc,awe,swe,dmwe,miso)", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drive inputs for one cycle and stop at its negedge for sampling.
  task automatic tick(input logic c, input logic s);
    @(posedge sclk);
    #1;
    cs  = c;
    sr0 = s;
    @(negedge sclk);
  endtask

  task automatic do_reset();
    cs    = 1'b1;
    sr0   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge sclk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int         rep;
    logic       c;
    logic       s;
    logic [5:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] obs[0:40];
  int         cyc_n, npulse, bad, nawe;
  logic       rc, rs;

  initial begin
    rst_n = 1'b0;

    // default-instance frames, one row per run of identical cycles
    tbl.push_back('{1, 1'b0, 1'b0, 6'b0});          // write: cycle 0 (STANDBY)
    tbl.push_back('{8, 1'b0, 1'b0, BUSY | AWE});    // cycles 1-8, R/W=0
    tbl.push_back('{7, 1'b0, 1'b0, BUSY});          // cycles 9-15 shifting in
    tbl.push_back('{1, 1'b0, 1'b0, BUSY | DMW});    // cycle 16 commit
    tbl.push_back('{2, 1'b1, 1'b0, 6'b0});          // back in STANDBY
    tbl.push_back('{1, 1'b0, 1'b0, 6'b0});          // read: cycle 0
    tbl.push_back('{7, 1'b0, 1'b0, BUSY | AWE});    // cycles 1-7
    tbl.push_back('{1, 1'b0, 1'b1, BUSY | AWE});    // cycle 8, R/W=1
    tbl.push_back('{1, 1'b0, 1'b0, BUSY | SWE});    // cycle 9 load
    tbl.push_back('{7, 1'b0, 1'b0, BUSY | MISO});   // cycles 10-16 shift out
    tbl.push_back('{2, 1'b1, 1'b0, 6'b0});          // cycle 17 STANDBY

    do_reset();
    tick(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) chk($sformatf("reset_state[%0d]", k), get_out(k), 6'b0);

    for (int r = 0; r < tbl.size(); r++) begin
      for (int i = 0; i < tbl[r].rep; i++) begin
        tick(tbl[r].c, tbl[r].s);
        chk($sformatf("table_row%0d_rep%0d", r, i), get_out(0), tbl[r].exp);
      end
    end

    // reset asserted mid-header (GET_ADDR, count=3)
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) tick(1'b0, 1'b0);
    chk("pre_reset_get_addr", get_out(0), BUSY | AWE);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("async_reset_outputs[%0d]", k), get_out(k), 6'b0);
    repeat (2) @(posedge sclk);
    #1 rst_n = 1'b1;
    cs = 1'b1;
    tick(1'b1, 1'b0);
    chk("after_reset_standby", get_out(0), 6'b0);

    // abort at WRITE_SHIFT count=3, then a fresh write frame
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 1; i <= 11; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("abort_cycle", get_out(0), BUSY);
    bad = 0;
    for (int i = 13; i <= 20; i++) begin
      tick(1'b1, 1'b0);
      if (dm[0] || bsy[0]) bad++;
    end
    chk_int("abort_no_commit_idle", bad, 0);
    tick(1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("fresh_frame_commit", get_out(0), BUSY | DMW);
    tick(1'b1, 1'b0);
    chk("fresh_frame_end", get_out(0), 6'b0);

    // burst 16-bit write, 3 words, then cs release
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    npulse = 0;
    bad    = 0;
    for (int c = 1; c <= 57; c++) begin
      tick((c == 57) ? 1'b1 : 1'b0, 1'b0);
      if (dm[1]) begin
        npulse++;
        if (!ainc[1] || c != 8 + 16 * npulse) bad++;
      end else if (ainc[1]) begin
        bad++;
      end
    end
    chk_int("burst_write_pulses", npulse, 3);
    chk_int("burst_write_pulse_timing", bad, 0);
    tick(1'b1, 1'b0);
    chk("burst_write_end", get_out(1), 6'b0);

    // 16-bit header, burst read of 2 words
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    nawe = 0;
    bad  = 0;
    for (int c = 1; c <= 26; c++) begin
      tick(1'b0, (c == 16) ? 1'b1 : 1'b0);
      obs[c] = get_out(2);
      if (awe[2]) begin
        nawe++;
        if (c > 16) bad++;
      end
    end
    chk_int("hdr16_addr_we_cycles", nawe, 16);
    chk_int("hdr16_addr_we_window", bad, 0);
    chk("hdr16_first_load", obs[17], BUSY | SWE);
    chk("hdr16_mid_shift", obs[23], BUSY | MISO);
    chk("hdr16_last_shift_inc", obs[24], BUSY | MISO | AINC);
    chk("hdr16_second_load", obs[25], BUSY | SWE);
    tick(1'b1, 1'b0);
    chk("hdr16_cs_release_cycle", get_out(2), BUSY | MISO);
    tick(1'b1, 1'b0);
    chk("hdr16_standby", get_out(2), 6'b0);

    // randomized traffic against the reference model, with occasional resets
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst_n = 1'b1;
      rc = ($urandom_range(0, 19) == 0);
      rs = 1'($urandom_range(0, 1));
      tick(rc, rs);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        #1;
      end
      for (int k = 0; k < 3; k++) begin
        cyc_n = n;
        chk($sformatf("random_c%0d_u%0d", cyc_n, k), get_out(k), model_exp(k));
      end
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
